// File: rtl/sram_ctrl_multibeat.sv
// sram_ctrl_multibeat: splits DATA_W-bit CPU loads/stores into WAIT_CYC-clock beats on an async SRAM
module sram_ctrl_multibeat #(
    parameter int DATA_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int BASE_ADDR = 1024,
    parameter int WAIT_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rd_en,
    input  logic                i_wr_en,
    input  logic [31:0]         i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_ready,
    inout  wire  [SRAM_DW-1:0]  io_sram_dq,
    output logic [SRAM_AW-1:0]  o_sram_addr,
    output logic                o_sram_we_n,
    output logic                o_sram_oe_n,
    output logic                o_sram_ce_n,
    output logic                o_sram_ub_n,
    output logic                o_sram_lb_n
);
    localparam int NB = DATA_W / SRAM_DW;
    localparam int SH = $clog2(DATA_W / 8);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW = $clog2(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [BW-1:0]      r_beat;
    logic [WW-1:0]      r_wait;
    logic               r_wr;
    logic [DATA_W-1:0]  r_rdata;
    logic [31:0]        w_off;
    logic [SRAM_AW-1:0] w_lin;
    logic               w_req, w_idle, w_acc, w_done, w_last_wait, w_last_beat;

    assign w_req       = i_rd_en | i_wr_en;
    assign w_idle      = r_state == S_IDLE;
    assign w_acc       = r_state == S_ACCESS;
    assign w_done      = r_state == S_DONE;
    assign w_last_wait = r_wait == WW'(WAIT_CYC - 1);
    assign w_last_beat = r_beat == BW'(NB - 1);
    // Offset wraps modulo 2^32; the SRAM address wraps at SRAM_AW bits.
    assign w_off       = i_addr - 32'(BASE_ADDR);
    assign w_lin       = SRAM_AW'(w_off >> SH) * SRAM_AW'(NB) + SRAM_AW'(r_beat);
    assign o_rdata     = r_rdata;
    assign io_sram_dq  = (w_acc && r_wr) ? i_wdata[r_beat*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        if (w_idle && w_req)
            w_next = S_ACCESS;
        else if (w_acc && w_last_wait && w_last_beat)
            w_next = S_DONE;
        else if (w_done)
            w_next = S_IDLE;
        o_ready     = (w_idle && !w_req) || w_done;
        o_sram_ce_n = !w_acc;
        o_sram_ub_n = !w_acc;
        o_sram_lb_n = !w_acc;
        o_sram_oe_n = !(w_acc && !r_wr);
        // WE_N rises on the last wait count so the write lands while address and data are stable.
        o_sram_we_n = !(w_acc && r_wr && !w_last_wait);
        o_sram_addr = w_acc ? w_lin : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat  <= '0;
            r_wait  <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else if (w_acc) begin
            r_wait <= w_last_wait ? '0 : r_wait + 1'b1;
            if (w_last_wait)
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            if (w_last_wait && !r_wr)
                r_rdata[r_beat*SRAM_DW +: SRAM_DW] <= io_sram_dq;
        end else begin
            r_beat <= '0;
            r_wait <= '0;
            if (w_idle && w_req)
                r_wr <= i_wr_en;
        end
    end
endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// tb_sram_ctrl_multibeat: table-driven directed checks of 32-bit/2-wait and 64-bit/3-wait controllers
module tb_sram_ctrl_multibeat;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd32, wr32, rd64, wr64;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [31:0] rdata32;
    logic [63:0] rdata64;
    logic        rdy32, rdy64;
    wire  [15:0] dq32, dq64;
    logic [17:0] sa32, sa64;
    logic        we32, oe32, ce32, ub32, lb32;
    logic        we64, oe64, ce64, ub64, lb64;
    logic [15:0] mem32 [0:262143];
    logic [15:0] mem64 [0:262143];
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    sram_ctrl_multibeat #(.DATA_W(32), .WAIT_CYC(2)) u32 (
        .clk(clk), .rst(rst), .i_rd_en(rd32), .i_wr_en(wr32), .i_addr(addr),
        .i_wdata(wdata[31:0]), .o_rdata(rdata32), .o_ready(rdy32), .io_sram_dq(dq32),
        .o_sram_addr(sa32), .o_sram_we_n(we32), .o_sram_oe_n(oe32), .o_sram_ce_n(ce32),
        .o_sram_ub_n(ub32), .o_sram_lb_n(lb32));

    sram_ctrl_multibeat #(.DATA_W(64), .WAIT_CYC(3)) u64 (
        .clk(clk), .rst(rst), .i_rd_en(rd64), .i_wr_en(wr64), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata64), .o_ready(rdy64), .io_sram_dq(dq64),
        .o_sram_addr(sa64), .o_sram_we_n(we64), .o_sram_oe_n(oe64), .o_sram_ce_n(ce64),
        .o_sram_ub_n(ub64), .o_sram_lb_n(lb64));

    // Async SRAM models: an undriven bus floats high so high-Z is observable.
    genvar k;
    for (k = 0; k < 16; k++) begin : g_pu
        pullup (dq32[k]);
        pullup (dq64[k]);
    end
    assign dq32 = (!ce32 && !oe32 && we32) ? mem32[sa32] : 16'bz;
    assign dq64 = (!ce64 && !oe64 && we64) ? mem64[sa64] : 16'bz;
    always @(posedge we32) if (!rst && !ce32) mem32[sa32] = dq32;
    always @(posedge we64) if (!rst && !ce64) mem64[sa64] = dq64;

    typedef struct {
        bit          wide;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic [17:0] exp_a0;
        int          exp_lat;
        int          exp_acc;
        int          exp_pulses;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_access(input bit wide, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [63:0] wd, output int lat, output int acc,
                             output int pulses, output int addr_bad, output logic [17:0] a0,
                             output logic [63:0] rout);
        int   wcyc;
        logic prev_we;
        wcyc = wide ? 3 : 2;
        @(posedge clk); #1;
        addr = a;
        wdata = wd;
        if (wide) {rd64, wr64} = {rd, wr};
        else {rd32, wr32} = {rd, wr};
        #1 check("ready_drops_on_request", wide ? rdy64 : rdy32, 1'b0);
        lat = 0; acc = 0; pulses = 0; addr_bad = 0; a0 = '0; prev_we = 1'b1;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!(wide ? ce64 : ce32)) begin
                if (acc == 0) a0 = wide ? sa64 : sa32;
                else if ((wide ? sa64 : sa32) != 18'(a0 + 18'(acc / wcyc))) addr_bad++;
                acc++;
            end
            if (prev_we && !(wide ? we64 : we32)) pulses++;
            prev_we = wide ? we64 : we32;
            if (wide ? rdy64 : rdy32) break;
        end
        rout = wide ? rdata64 : {32'h0, rdata32};
        {rd32, wr32, rd64, wr64} = '0;
    endtask

    initial begin
        vec_t        v [8];
        int          lat, acc, pulses, bad, n;
        logic [17:0] a0;
        logic [63:0] r;
        v[0] = '{0, 1, 0, 32'd1024, 64'h0,                  64'hABCD1234,          18'h0,     5, 4, 0};
        v[1] = '{0, 0, 1, 32'd1028, 64'hDEADBEEF,           64'hABCD1234,          18'h2,     5, 4, 2};
        v[2] = '{0, 1, 0, 32'd1028, 64'h0,                  64'hDEADBEEF,          18'h2,     5, 4, 0};
        v[3] = '{0, 1, 1, 32'd1032, 64'hCAFEF00D,           64'hDEADBEEF,          18'h4,     5, 4, 2};
        v[4] = '{0, 1, 0, 32'd1020, 64'h0,                  64'h66665555,          18'h3FFFE, 5, 4, 0};
        v[5] = '{1, 0, 1, 32'd1032, 64'h0123456789ABCDEF,   64'h0,                 18'h4,     13, 12, 4};
        v[6] = '{1, 1, 0, 32'd1032, 64'h0,                  64'h0123456789ABCDEF,  18'h4,     13, 12, 0};
        v[7] = '{0, 1, 0, 32'd1026, 64'h0,                  64'hABCD1234,          18'h0,     5, 4, 0};
        mem32[0] = 16'h1234;
        mem32[1] = 16'hABCD;
        mem32[6] = 16'hAAAA;
        mem32[7] = 16'h7777;
        mem32[18'h3FFFE] = 16'h5555;
        mem32[18'h3FFFF] = 16'h6666;
        rst = 1'b1;
        {rd32, wr32, rd64, wr64} = '0;
        addr = '0;
        wdata = '0;
        #2;
        check("reset_ready", {rdy32, rdy64}, 2'b11);
        check("reset_rdata", {rdata32, rdata64}, 96'h0);
        check("reset_addr", {sa32, sa64}, 36'h0);
        check("reset_strobes", {we32, oe32, ce32, ub32, lb32}, 5'b11111);
        check("reset_dq_z", dq32, 16'hFFFF);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_access(v[i].wide, v[i].rd, v[i].wr, v[i].addr, v[i].wdata, lat, acc, pulses, bad, a0, r);
            check($sformatf("row%0d_latency", i), lat, v[i].exp_lat);
            check($sformatf("row%0d_access_cycles", i), acc, v[i].exp_acc);
            check($sformatf("row%0d_we_pulses", i), pulses, v[i].exp_pulses);
            check($sformatf("row%0d_first_addr", i), a0, v[i].exp_a0);
            check($sformatf("row%0d_addr_sequence_errors", i), bad, 0);
            check($sformatf("row%0d_rdata", i), r, v[i].exp_rdata);
        end
        check("mem32_2", mem32[2], 16'hBEEF);
        check("mem32_3", mem32[3], 16'hDEAD);
        check("mem32_4", mem32[4], 16'hF00D);
        check("mem32_5", mem32[5], 16'hCAFE);
        check("mem64_4_7", {mem64[7], mem64[6], mem64[5], mem64[4]}, 64'h0123456789ABCDEF);

        // Back-to-back: request held through DONE restarts from IDLE.
        @(posedge clk); #1;
        addr = 32'd1024;
        rd32 = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rdy32 && n < 50);
        check("b2b_first_latency", n, 5);
        @(posedge clk); #1;
        check("b2b_idle_ready_low", {rdy32, ce32}, 2'b01);
        @(posedge clk); #1;
        check("b2b_second_access", ce32, 1'b0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rdy32 && n < 50);
        rd32 = 1'b0;
        check("b2b_second_done", n, 4);
        check("b2b_rdata", rdata32, 32'hABCD1234);

        // Reset in beat 1 of a write: SRAM[7] must keep its old value.
        @(posedge clk); #1;
        addr = 32'd1036;
        wdata = 64'h11112222;
        wr32 = 1'b1;
        n = 0;
        while (!(sa32 == 18'd7 && !ce32) && n < 50) begin @(posedge clk); #1; n++; end
        check("abort_reached_beat1", n < 50, 1'b1);
        check("abort_beat1_driving", {we32, dq32}, {1'b0, 16'h1111});
        rst = 1'b1;
        wr32 = 1'b0;
        #1;
        check("abort_we_high", we32, 1'b1);
        check("abort_dq_z", dq32, 16'hFFFF);
        check("abort_ready", rdy32, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_beat0_written", mem32[6], 16'h2222);
        check("abort_beat1_not_written", mem32[7], 16'h7777);
        check("abort_rdata_cleared", rdata32, 32'h0);
        do_access(0, 1, 0, 32'd1024, 64'h0, lat, acc, pulses, bad, a0, r);
        check("post_abort_latency", lat, 5);
        check("post_abort_first_addr", a0, 18'h0);
        check("post_abort_rdata", r, 64'hABCD1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
